// File: rtl/rv32i_instr_encoder.sv
// rv32i_instr_encoder
// Turns a mnemonic plus operand description into an RV32I instruction word,
// tags it with a running instruction-memory address and hands it downstream
// through a 2-entry FIFO with a valid/ready handshake on both sides.
//
// Mnemonic ordinals:
//   R  : ADD=0 SUB=1 SLL=2 SRL=3 SRA=4 AND=5 OR=6 XOR=7 SLT=8 SLTU=9
//   I  : ADDI=10 SLLI=11 SRLI=12 SRAI=13 ANDI=14 ORI=15 XORI=16 SLTI=17 SLTIU=18
//   LD : LB=19 LH=20 LW=21 LBU=22 LHU=23   JALR=24   ECALL=25 EBREAK=26
//   S  : SB=27 SH=28 SW=29
//   B  : BEQ=30 BNE=31 BLT=32 BGE=33 BLTU=34 BGEU=35
//   JAL=36 LUI=37 AUIPC=38 NULL=39 (39 and above are rejected)
//
// Optional feature: define RV32I_ENC_IMM_CHECK_EN to reject requests whose
// immediate does not fit the encoded field; otherwise immediates are truncated.

module rv32i_instr_encoder #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  in_mnem,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // funct3 for every mnemonic that carries one; zero elsewhere
    function automatic logic [2:0] funct3_of(input logic [5:0] m);
        logic [2:0] f3;
        case (m)
            6'd0, 6'd1, 6'd10, 6'd19, 6'd24, 6'd27, 6'd30:  f3 = 3'b000;
            6'd2, 6'd11, 6'd20, 6'd28, 6'd31:               f3 = 3'b001;
            6'd8, 6'd17, 6'd21, 6'd29:                      f3 = 3'b010;
            6'd9, 6'd18:                                    f3 = 3'b011;
            6'd7, 6'd16, 6'd22, 6'd32:                      f3 = 3'b100;
            6'd3, 6'd4, 6'd12, 6'd13, 6'd23, 6'd33:         f3 = 3'b101;
            6'd6, 6'd15, 6'd34:                             f3 = 3'b110;
            6'd5, 6'd14, 6'd35:                             f3 = 3'b111;
            default:                                        f3 = 3'b000;
        endcase
        return f3;
    endfunction

    // Assemble the instruction word; fields a format does not use stay zero
    function automatic logic [31:0] encode(
        input logic [5:0]  m,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [31:0] imm
    );
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] w;
        f3 = funct3_of(m);
        f7 = ((m == 6'd1) || (m == 6'd4) || (m == 6'd13)) ? 7'b0100000 : 7'b0000000;
        if (m <= 6'd9) begin
            w = {f7, rs2, rs1, f3, rd, OPC_OP};
        end else if ((m >= 6'd11) && (m <= 6'd13)) begin
            w = {f7, imm[4:0], rs1, f3, rd, OPC_OP_IMM};
        end else if (m <= 6'd18) begin
            w = {imm[11:0], rs1, f3, rd, OPC_OP_IMM};
        end else if (m <= 6'd23) begin
            w = {imm[11:0], rs1, f3, rd, OPC_LOAD};
        end else if (m == 6'd24) begin
            w = {imm[11:0], rs1, 3'b000, rd, OPC_JALR};
        end else if (m == 6'd25) begin
            w = 32'h0000_0073;
        end else if (m == 6'd26) begin
            w = 32'h0010_0073;
        end else if (m <= 6'd29) begin
            w = {imm[11:5], rs2, rs1, f3, imm[4:0], OPC_STORE};
        end else if (m <= 6'd35) begin
            w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OPC_BRANCH};
        end else if (m == 6'd36) begin
            w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OPC_JAL};
        end else if (m == 6'd37) begin
            w = {imm[31:12], rd, OPC_LUI};
        end else if (m == 6'd38) begin
            w = {imm[31:12], rd, OPC_AUIPC};
        end else begin
            w = 32'h0000_0000;
        end
        return w;
    endfunction

`ifdef RV32I_ENC_IMM_CHECK_EN
    // True when the immediate fits the field the mnemonic encodes it into
    function automatic logic imm_in_range(input logic [5:0] m, input logic [31:0] imm);
        logic ok;
        if ((m >= 6'd11) && (m <= 6'd13)) begin
            ok = (imm[31:5] == 27'd0);
        end else if (((m >= 6'd10) && (m <= 6'd24)) || ((m >= 6'd27) && (m <= 6'd29))) begin
            ok = (&imm[31:11]) || !(|imm[31:11]);
        end else if ((m >= 6'd30) && (m <= 6'd35)) begin
            ok = ((&imm[31:12]) || !(|imm[31:12])) && !imm[0];
        end else if (m == 6'd36) begin
            ok = ((&imm[31:20]) || !(|imm[31:20])) && !imm[0];
        end else if ((m == 6'd37) || (m == 6'd38)) begin
            ok = (imm[11:0] == 12'd0);
        end else begin
            ok = 1'b1;
        end
        return ok;
    endfunction
`endif

    state_t      state_q, state_d;
    logic [31:0] head_instr_q, head_instr_d;
    logic [31:0] head_addr_q, head_addr_d;
    logic [31:0] tail_instr_q, tail_instr_d;
    logic [31:0] tail_addr_q, tail_addr_d;
    logic [31:0] cnt_q, cnt_d;
    logic        out_valid_q, out_valid_d;
    logic        in_ready_q, in_ready_d;
    logic        err_q, err_d;

    logic        accept_s;
    logic        legal_s;
    logic        push_s;
    logic        pop_s;
    logic [31:0] word_s;

    assign accept_s = in_valid && in_ready_q;
`ifdef RV32I_ENC_IMM_CHECK_EN
    assign legal_s  = (in_mnem < 6'd39) && imm_in_range(in_mnem, in_imm);
`else
    assign legal_s  = (in_mnem < 6'd39);
`endif
    assign push_s   = accept_s && legal_s;
    assign pop_s    = out_valid_q && out_ready;
    assign word_s   = encode(in_mnem, in_rd, in_rs1, in_rs2, in_imm);

    // FIFO occupancy, entry contents, address counter and error pulse
    always_comb begin
        state_d      = state_q;
        head_instr_d = head_instr_q;
        head_addr_d  = head_addr_q;
        tail_instr_d = tail_instr_q;
        tail_addr_d  = tail_addr_q;
        cnt_d        = cnt_q;
        err_d        = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
            cnt_d   = BASE_ADDR;
        end else begin
            if (accept_s && !legal_s) begin
                err_d = 1'b1;
            end else begin
                err_d = 1'b0;
            end
            if (push_s) begin
                cnt_d = cnt_q + 32'd4;
            end else begin
                cnt_d = cnt_q;
            end
            case (state_q)
                ST_EMPTY: begin
                    if (push_s) begin
                        head_instr_d = word_s;
                        head_addr_d  = cnt_q;
                        state_d      = ST_ONE;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (push_s && pop_s) begin
                        head_instr_d = word_s;
                        head_addr_d  = cnt_q;
                        state_d      = ST_ONE;
                    end else if (push_s) begin
                        tail_instr_d = word_s;
                        tail_addr_d  = cnt_q;
                        state_d      = ST_FULL;
                    end else if (pop_s) begin
                        state_d = ST_EMPTY;
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    // in_ready is low while full, so no push can land here
                    if (pop_s) begin
                        head_instr_d = tail_instr_q;
                        head_addr_d  = tail_addr_q;
                        state_d      = ST_ONE;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != ST_EMPTY);
        in_ready_d  = (state_d != ST_FULL);
    end

    // State and output registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_EMPTY;
            head_instr_q <= 32'h0000_0000;
            head_addr_q  <= BASE_ADDR;
            tail_instr_q <= 32'h0000_0000;
            tail_addr_q  <= BASE_ADDR;
            cnt_q        <= BASE_ADDR;
            out_valid_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            head_instr_q <= head_instr_d;
            head_addr_q  <= head_addr_d;
            tail_instr_q <= tail_instr_d;
            tail_addr_q  <= tail_addr_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            in_ready_q   <= in_ready_d;
            err_q        <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_instr = head_instr_q;
    assign out_addr  = head_addr_q;
    assign err       = err_q;

endmodule

// File: tb/tb_rv32i_instr_encoder.sv
// Self-checking bench for rv32i_instr_encoder: directed vector table,
// back-pressure / reject / flush / reset sequences, and randomized traffic
// checked against a queue-based reference model.
module tb_rv32i_instr_encoder;

    localparam logic [31:0] BASE = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_mnem;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [31:0] in_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_addr;
    logic        err;

    rv32i_instr_encoder #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_mnem(in_mnem), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_addr(out_addr), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // funct3 tables per instruction group, in mnemonic order
    int r_f3 [0:9] = '{0, 0, 1, 5, 5, 7, 6, 4, 2, 3};
    int i_f3 [0:8] = '{0, 1, 5, 5, 7, 6, 4, 2, 3};
    int l_f3 [0:4] = '{0, 1, 2, 4, 5};
    int s_f3 [0:2] = '{0, 1, 2};
    int b_f3 [0:5] = '{0, 1, 4, 5, 6, 7};

    // reference model state
    logic [31:0] mq_instr [$];
    logic [31:0] mq_addr  [$];
    logic [31:0] m_cnt;
    bit          m_err;

    function automatic logic [31:0] bitv(logic [31:0] v, int i);
        return (v >> i) & 32'd1;
    endfunction

    function automatic logic [31:0] ref_encode(int m, int rd, int rs1, int rs2, logic [31:0] imm);
        logic [31:0] rr;
        logic [31:0] w;
        rr = rs2 * 32'd1048576 + rs1 * 32'd32768;
        if (m < 10) begin
            w = ((m == 1 || m == 4) ? 32'd32 : 32'd0) * 32'd33554432 + rr + r_f3[m] * 32'd4096 + rd * 32'd128 + 32'd51;
        end else if (m < 19) begin
            if (m >= 11 && m <= 13)
                w = ((m == 13) ? 32'd32 : 32'd0) * 32'd33554432 + (imm & 32'd31) * 32'd1048576
                    + rs1 * 32'd32768 + i_f3[m-10] * 32'd4096 + rd * 32'd128 + 32'd19;
            else
                w = (imm & 32'd4095) * 32'd1048576 + rs1 * 32'd32768 + i_f3[m-10] * 32'd4096 + rd * 32'd128 + 32'd19;
        end else if (m < 24) begin
            w = (imm & 32'd4095) * 32'd1048576 + rs1 * 32'd32768 + l_f3[m-19] * 32'd4096 + rd * 32'd128 + 32'd3;
        end else if (m == 24) begin
            w = (imm & 32'd4095) * 32'd1048576 + rs1 * 32'd32768 + rd * 32'd128 + 32'd103;
        end else if (m == 25) begin
            w = 32'h0000_0073;
        end else if (m == 26) begin
            w = 32'h0010_0073;
        end else if (m < 30) begin
            w = ((imm >> 5) & 32'd127) * 32'd33554432 + rr + s_f3[m-27] * 32'd4096 + (imm & 32'd31) * 32'd128 + 32'd35;
        end else if (m < 36) begin
            w = bitv(imm, 12) * 32'h8000_0000 + ((imm >> 5) & 32'd63) * 32'd33554432 + rr
                + b_f3[m-30] * 32'd4096 + ((imm >> 1) & 32'd15) * 32'd256 + bitv(imm, 11) * 32'd128 + 32'd99;
        end else if (m == 36) begin
            w = bitv(imm, 20) * 32'h8000_0000 + ((imm >> 1) & 32'd1023) * 32'd2097152
                + bitv(imm, 11) * 32'd1048576 + ((imm >> 12) & 32'd255) * 32'd4096 + rd * 32'd128 + 32'd111;
        end else begin
            w = (imm & 32'hFFFF_F000) + rd * 32'd128 + ((m == 37) ? 32'd55 : 32'd23);
        end
        return w;
    endfunction

    function automatic bit ref_legal(int m, logic [31:0] imm);
        bit ok;
        int s;
        ok = (m < 39);
        s  = $signed(imm);
`ifdef RV32I_ENC_IMM_CHECK_EN
        if (m >= 11 && m <= 13)                         ok = ok && (imm <= 32'd31);
        else if ((m >= 10 && m <= 24) || (m >= 27 && m <= 29)) ok = ok && (s >= -2048) && (s <= 2047);
        else if (m >= 30 && m <= 35)                    ok = ok && (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
        else if (m == 36)                               ok = ok && (s >= -1048576) && (s <= 1048575) && (imm[0] == 1'b0);
        else if (m == 37 || m == 38)                    ok = ok && ((imm % 32'd4096) == 32'd0);
`endif
        return ok;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq_instr.delete();
        mq_addr.delete();
        m_cnt = BASE;
        m_err = 1'b0;
    endtask

    task automatic check_all();
        chk("out_valid", {31'd0, out_valid}, {31'd0, mq_instr.size() > 0});
        chk("in_ready",  {31'd0, in_ready},  {31'd0, mq_instr.size() < 2});
        chk("err",       {31'd0, err},       {31'd0, m_err});
        if (mq_instr.size() > 0) begin
            chk("out_instr", out_instr, mq_instr[0]);
            chk("out_addr",  out_addr,  mq_addr[0]);
        end
    endtask

    // advance one clock, update the model with the pre-edge inputs, then check
    task automatic cycle();
        bit acc, pop, lg, fl;
        logic [31:0] w;
        fl  = flush;
        acc = in_valid && (mq_instr.size() < 2);
        pop = out_ready && (mq_instr.size() > 0);
        lg  = ref_legal(int'(in_mnem), in_imm);
        w   = ref_encode(int'(in_mnem), int'(in_rd), int'(in_rs1), int'(in_rs2), in_imm);
        @(posedge clk);
        m_err = 1'b0;
        if (fl) begin
            mq_instr.delete();
            mq_addr.delete();
            m_cnt = BASE;
        end else begin
            if (pop) begin
                void'(mq_instr.pop_front());
                void'(mq_addr.pop_front());
            end
            if (acc && lg) begin
                mq_instr.push_back(w);
                mq_addr.push_back(m_cnt);
                m_cnt = m_cnt + 32'd4;
            end else if (acc) begin
                m_err = 1'b1;
            end
        end
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [5:0] m, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        in_valid = v;
        in_mnem  = m;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
    endtask

    typedef struct {
        logic [5:0]  m;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [0:13];

    initial begin
        logic [31:0] cnt_before;

        tbl[0]  = '{6'd10, 5'd1,  5'd0,  5'd0,  32'd5,          32'h0050_0093}; // ADDI
        tbl[1]  = '{6'd0,  5'd3,  5'd1,  5'd2,  32'd0,          32'h0020_81B3}; // ADD
        tbl[2]  = '{6'd29, 5'd7,  5'd1,  5'd2,  32'd8,          32'h0020_A423}; // SW
        tbl[3]  = '{6'd30, 5'd9,  5'd1,  5'd2,  32'd8,          32'h0020_8463}; // BEQ
        tbl[4]  = '{6'd36, 5'd1,  5'd3,  5'd4,  32'd16,         32'h0100_00EF}; // JAL
        tbl[5]  = '{6'd37, 5'd5,  5'd0,  5'd0,  32'h1234_5000,  32'h1234_52B7}; // LUI
        tbl[6]  = '{6'd1,  5'd5,  5'd6,  5'd7,  32'd0,          32'h4073_02B3}; // SUB
        tbl[7]  = '{6'd13, 5'd1,  5'd2,  5'd31, 32'd3,          32'h4031_5093}; // SRAI
        tbl[8]  = '{6'd25, 5'd31, 5'd31, 5'd31, 32'hFFFF_FFFF,  32'h0000_0073}; // ECALL
        tbl[9]  = '{6'd26, 5'd17, 5'd4,  5'd9,  32'h0000_1234,  32'h0010_0073}; // EBREAK
        tbl[10] = '{6'd21, 5'd1,  5'd2,  5'd0,  32'hFFFF_FFFC,  32'hFFC1_2083}; // LW -4
        tbl[11] = '{6'd35, 5'd0,  5'd1,  5'd2,  32'hFFFF_FFF8,  32'hFE20_FCE3}; // BGEU -8
        tbl[12] = '{6'd38, 5'd2,  5'd0,  5'd0,  32'hABCD_E000,  32'hABCD_E117}; // AUIPC
        tbl[13] = '{6'd18, 5'd4,  5'd5,  5'd0,  32'h0000_07FF,  32'h7FF2_B213}; // SLTIU

        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_err",       {31'd0, err},       32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr",  out_addr,  BASE);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle();

        // directed vectors, one request every other cycle
        for (int i = 0; i < 14; i++) begin
            drive(1'b1, tbl[i].m, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].imm);
            cycle();
            chk("tbl_valid", {31'd0, out_valid}, 32'd1);
            chk("tbl_instr", out_instr, tbl[i].exp);
            chk("tbl_addr",  out_addr,  BASE + 32'(4 * i));
            drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
            cycle();
        end

        // back-pressure: three requests with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 6'd10, 5'd1, 5'd0, 5'd0, 32'd1);
        cycle();
        drive(1'b1, 6'd10, 5'd2, 5'd0, 5'd0, 32'd2);
        cycle();
        drive(1'b1, 6'd10, 5'd3, 5'd0, 5'd0, 32'd3);
        cycle();
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        cycle();
        chk("bp_hold_instr", out_instr, 32'h0010_0093);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        cycle();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        chk("bp_drained", {31'd0, out_valid}, 32'd0);

        // rejection: NULL mnemonic
        cnt_before = m_cnt;
        drive(1'b1, 6'd39, 5'd1, 5'd1, 5'd1, 32'd0);
        cycle();
        chk("rej_err", {31'd0, err}, 32'd1);
        chk("rej_no_valid", {31'd0, out_valid}, 32'd0);
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        cycle();
        chk("rej_err_pulse", {31'd0, err}, 32'd0);
        // ADDI with an immediate wider than 12 bits
        drive(1'b1, 6'd10, 5'd1, 5'd0, 5'd0, 32'd4096);
        cycle();
`ifdef RV32I_ENC_IMM_CHECK_EN
        chk("imm_rej_err", {31'd0, err}, 32'd1);
`else
        chk("imm_trunc_instr", out_instr, 32'h0000_0093);
`endif
        drive(1'b1, 6'd10, 5'd1, 5'd0, 5'd0, 32'd7);
        cycle();
        chk("rej_addr", out_addr, ref_legal(10, 32'd4096) ? cnt_before + 32'd4 : cnt_before);
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        cycle();

        // flush with a same-cycle request
        out_ready = 1'b0;
        drive(1'b1, 6'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        cycle();
        flush = 1'b1;
        drive(1'b1, 6'd1, 5'd4, 5'd5, 5'd6, 32'd0);
        cycle();
        flush = 1'b0;
        chk("flush_empty", {31'd0, out_valid}, 32'd0);
        drive(1'b1, 6'd10, 5'd9, 5'd9, 5'd0, 32'd9);
        cycle();
        chk("flush_addr", out_addr, BASE);
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        out_ready = 1'b1;
        cycle();

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [5:0] m;
            logic [31:0] imm;
            m   = ($urandom_range(7) == 0) ? 6'(39 + $urandom_range(24)) : 6'($urandom_range(38));
            imm = ($urandom_range(1) == 0) ? 32'($urandom_range(64)) - 32'd32 : 32'($urandom);
            drive($urandom_range(3) != 0, m, 5'($urandom), 5'($urandom), 5'($urandom), imm);
            out_ready = ($urandom_range(3) != 0);
            flush = ($urandom_range(49) == 0);
            cycle();
        end
        flush = 1'b0;
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0);

        // reset with a full FIFO, asserted between clock edges
        out_ready = 1'b0;
        cycle();
        drive(1'b1, 6'd10, 5'd1, 5'd0, 5'd0, 32'd1);
        cycle();
        cycle();
        cycle();
        chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid_ready", {31'd0, in_ready},  32'd1);
        chk("rst_mid_addr",  out_addr, BASE);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, 6'd0, 5'd3, 5'd1, 5'd2, 32'd0);
        cycle();
        chk("post_rst_addr",  out_addr,  BASE);
        chk("post_rst_instr", out_instr, 32'h0020_81B3);
        drive(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        out_ready = 1'b1;
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
